// File: rtl/writeback_arbiter.sv
// Register-file writeback arbiter: load results always win, ALU results wait in a
// small FIFO when they lose. Also reports pending writes to the decode stage.
module writeback_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iAluValid,
  input  logic [4:0]  iAluAddr,
  input  logic [31:0] iAluData,
  output logic        oAluReady,
  input  logic        iMemValid,
  input  logic [4:0]  iMemAddr,
  input  logic [31:0] iMemData,
  output logic [4:0]  oWAddr,
  output logic [31:0] oWData,
  output logic        oWe,
  input  logic [4:0]  iQAddr1,
  input  logic [4:0]  iQAddr2,
  output logic        oQHit1,
  output logic        oQHit2
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [4:0]    addrMem [DEPTH];
  logic [31:0]   dataMem [DEPTH];
  logic [PW-1:0] wrPtr, rdPtr;
  logic [CW-1:0] count;

  logic          fifoEmpty, aluAccept, push, pop;
  logic          selValid;
  logic [4:0]    selAddr;
  logic [31:0]   selData;
  logic [DEPTH-1:0] entryValid;

  assign fifoEmpty = (count == '0);
  assign oAluReady = (count < CW'(DEPTH));
  assign aluAccept = iAluValid && oAluReady;
  assign pop       = !iMemValid && !fifoEmpty;
  // An accepted ALU result queues unless it can go straight to the port this cycle.
  assign push      = aluAccept && (iMemValid || !fifoEmpty);

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    selValid = 1'b0;
    selAddr  = '0;
    selData  = '0;
    if (iMemValid) begin
      selValid = 1'b1;
      selAddr  = iMemAddr;
      selData  = iMemData;
    end else if (!fifoEmpty) begin
      selValid = 1'b1;
      selAddr  = addrMem[rdPtr];
      selData  = dataMem[rdPtr];
    end else if (aluAccept) begin
      selValid = 1'b1;
      selAddr  = iAluAddr;
      selData  = iAluData;
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr  <= '0;
      rdPtr  <= '0;
      count  <= '0;
      oWe    <= 1'b0;
      oWAddr <= '0;
      oWData <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PW'(1);
      if (pop)  rdPtr <= rdPtr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      oWe <= selValid && (selAddr != 5'd0);
      if (selValid) begin
        oWAddr <= selAddr;
        oWData <= selData;
      end
    end
  end

  // NOTE: storage is not reset; count alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      addrMem[wrPtr] <= iAluAddr;
      dataMem[wrPtr] <= iAluData;
    end
  end

  // An entry is live when its distance from the read pointer is below count.
  always_comb begin
    logic [PW-1:0] offset;
    entryValid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset        = PW'(i) - rdPtr;
      entryValid[i] = (CW'(offset) < count);
    end
  end

  always_comb begin
    oQHit1 = oWe && (oWAddr == iQAddr1);
    oQHit2 = oWe && (oWAddr == iQAddr2);
    for (int i = 0; i < DEPTH; i++) begin
      if (entryValid[i] && addrMem[i] == iQAddr1) oQHit1 = 1'b1;
      if (entryValid[i] && addrMem[i] == iQAddr2) oQHit2 = 1'b1;
    end
    if (iQAddr1 == 5'd0) oQHit1 = 1'b0;
    if (iQAddr2 == 5'd0) oQHit2 = 1'b0;
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: each task drives one scenario and checks
// outputs 1 time unit after the rising edge against hand-computed values.
module tb_writeback_arbiter;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        iAluValid;
  logic [4:0]  iAluAddr;
  logic [31:0] iAluData;
  logic        oAluReady;
  logic        iMemValid;
  logic [4:0]  iMemAddr;
  logic [31:0] iMemData;
  logic [4:0]  oWAddr;
  logic [31:0] oWData;
  logic        oWe;
  logic [4:0]  iQAddr1, iQAddr2;
  logic        oQHit1, oQHit2;

  int passed = 0;
  int total  = 0;

  writeback_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .iAluValid(iAluValid), .iAluAddr(iAluAddr), .iAluData(iAluData), .oAluReady(oAluReady),
    .iMemValid(iMemValid), .iMemAddr(iMemAddr), .iMemData(iMemData),
    .oWAddr(oWAddr), .oWData(oWData), .oWe(oWe),
    .iQAddr1(iQAddr1), .iQAddr2(iQAddr2), .oQHit1(oQHit1), .oQHit2(oQHit2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    iAluValid = 1'b0; iAluAddr = '0; iAluData = '0;
    iMemValid = 1'b0; iMemAddr = '0; iMemData = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idleInputs();
    iQAddr1 = 5'd5; iQAddr2 = 5'd0;
    #3;
    total++; if (oWe !== 1'b0) $display("FAIL rst_we got=%0b exp=0", oWe); else passed++;
    total++; if (oWAddr !== 5'd0) $display("FAIL rst_waddr got=%0d exp=0", oWAddr); else passed++;
    total++; if (oWData !== 32'd0) $display("FAIL rst_wdata got=%0h exp=0", oWData); else passed++;
    total++; if (oAluReady !== 1'b1) $display("FAIL rst_ready got=%0b exp=1", oAluReady); else passed++;
    total++; if (oQHit1 !== 1'b0) $display("FAIL rst_hit1 got=%0b exp=0", oQHit1); else passed++;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    step();
    total++; if (oWe !== 1'b0) $display("FAIL rst_release_we got=%0b exp=0", oWe); else passed++;
  endtask

  task automatic test_alu_only();
    iAluValid = 1'b1; iAluAddr = 5'd5; iAluData = 32'h11;
    step();
    idleInputs();
    total++; if (oWe !== 1'b1) $display("FAIL alu_we got=%0b exp=1", oWe); else passed++;
    total++; if (oWAddr !== 5'd5) $display("FAIL alu_waddr got=%0d exp=5", oWAddr); else passed++;
    total++; if (oWData !== 32'h11) $display("FAIL alu_wdata got=%0h exp=11", oWData); else passed++;
    step();
    total++; if (oWe !== 1'b0) $display("FAIL alu_one_cycle got=%0b exp=0", oWe); else passed++;
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 3; i++) begin
      iAluValid = 1'b1; iAluAddr = 5'(i); iAluData = 32'h50 + 32'(i);
      step();
      total++;
      if (oWe !== 1'b1 || oWAddr !== 5'(i) || oWData !== 32'h50 + 32'(i))
        $display("FAIL b2b_%0d got we=%0b addr=%0d data=%0h exp we=1 addr=%0d data=%0h",
                 i, oWe, oWAddr, oWData, i, 32'h50 + 32'(i));
      else passed++;
    end
    idleInputs();
    step();
    total++; if (oWe !== 1'b0) $display("FAIL b2b_idle got=%0b exp=0", oWe); else passed++;
  endtask

  task automatic test_collision();
    iMemValid = 1'b1; iMemAddr = 5'd3; iMemData = 32'hAA;
    iAluValid = 1'b1; iAluAddr = 5'd3; iAluData = 32'hBB;
    iQAddr1 = 5'd3;
    step();
    idleInputs();
    total++; if (oWe !== 1'b1 || oWAddr !== 5'd3 || oWData !== 32'hAA)
      $display("FAIL coll_mem got we=%0b addr=%0d data=%0h exp we=1 addr=3 data=aa", oWe, oWAddr, oWData);
    else passed++;
    total++; if (oQHit1 !== 1'b1) $display("FAIL coll_hit got=%0b exp=1", oQHit1); else passed++;
    step();
    total++; if (oWe !== 1'b1 || oWAddr !== 5'd3 || oWData !== 32'hBB)
      $display("FAIL coll_alu got we=%0b addr=%0d data=%0h exp we=1 addr=3 data=bb", oWe, oWAddr, oWData);
    else passed++;
    step();
    total++; if (oWe !== 1'b0) $display("FAIL coll_done got=%0b exp=0", oWe); else passed++;
    total++; if (oQHit1 !== 1'b0) $display("FAIL coll_hit_clear got=%0b exp=0", oQHit1); else passed++;
  endtask

  task automatic test_full();
    int k = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      iMemValid = 1'b1; iMemAddr = 5'd10 + 5'(i); iMemData = 32'h100 + 32'(i);
      iAluValid = 1'b1; iAluAddr = 5'd20 + 5'(k); iAluData = 32'h200 + 32'(k);
      total++;
      if (oAluReady !== (i < DEPTH)) $display("FAIL full_ready_%0d got=%0b exp=%0b", i, oAluReady, i < DEPTH);
      else passed++;
      step();
      if (i < DEPTH) k++;
      total++;
      if (oWe !== 1'b1 || oWAddr !== 5'd10 + 5'(i) || oWData !== 32'h100 + 32'(i))
        $display("FAIL full_mem_%0d got addr=%0d data=%0h exp addr=%0d data=%0h",
                 i, oWAddr, oWData, 10 + i, 32'h100 + 32'(i));
      else passed++;
    end
    iMemValid = 1'b0;
    iQAddr2 = 5'd22;
    #1;
    total++; if (oQHit2 !== 1'b1) $display("FAIL full_hit_q got=%0b exp=1", oQHit2); else passed++;
    iQAddr2 = 5'd25;
    #1;
    total++; if (oQHit2 !== 1'b0) $display("FAIL full_miss_q got=%0b exp=0", oQHit2); else passed++;
    // ALU still holds entry 24 while the FIFO is full and draining: must not push.
    total++; if (oAluReady !== 1'b0) $display("FAIL full_ready_pop got=%0b exp=0", oAluReady); else passed++;
    step();
    iAluValid = 1'b0;
    for (int j = 0; j < DEPTH; j++) begin
      if (j > 0) step();
      total++;
      if (oWe !== 1'b1 || oWAddr !== 5'd20 + 5'(j) || oWData !== 32'h200 + 32'(j))
        $display("FAIL full_drain_%0d got we=%0b addr=%0d data=%0h exp we=1 addr=%0d data=%0h",
                 j, oWe, oWAddr, oWData, 20 + j, 32'h200 + 32'(j));
      else passed++;
    end
    step();
    total++; if (oWe !== 1'b0) $display("FAIL full_empty_we got=%0b exp=0", oWe); else passed++;
    total++; if (oAluReady !== 1'b1) $display("FAIL full_empty_ready got=%0b exp=1", oAluReady); else passed++;
    idleInputs();
  endtask

  task automatic test_reg0();
    iQAddr1 = 5'd0;
    iAluValid = 1'b1; iAluAddr = 5'd0; iAluData = 32'hFF;
    step();
    idleInputs();
    total++; if (oWe !== 1'b0) $display("FAIL r0_we got=%0b exp=0", oWe); else passed++;
    total++; if (oWData !== 32'hFF) $display("FAIL r0_wdata got=%0h exp=ff", oWData); else passed++;
    total++; if (oQHit1 !== 1'b0) $display("FAIL r0_hit got=%0b exp=0", oQHit1); else passed++;
    iMemValid = 1'b1; iMemAddr = 5'd7; iMemData = 32'h1;
    iAluValid = 1'b1; iAluAddr = 5'd0; iAluData = 32'hEE;
    step();
    idleInputs();
    total++; if (oQHit1 !== 1'b0) $display("FAIL r0_hit_queued got=%0b exp=0", oQHit1); else passed++;
    total++; if (oWe !== 1'b1 || oWAddr !== 5'd7) $display("FAIL r0_mem got we=%0b addr=%0d exp we=1 addr=7", oWe, oWAddr); else passed++;
    step();
    total++; if (oWe !== 1'b0 || oWAddr !== 5'd0 || oWData !== 32'hEE)
      $display("FAIL r0_slot got we=%0b addr=%0d data=%0h exp we=0 addr=0 data=ee", oWe, oWAddr, oWData);
    else passed++;
    step();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      iMemValid = 1'b1; iMemAddr = 5'd8 + 5'(i); iMemData = 32'h300 + 32'(i);
      iAluValid = 1'b1; iAluAddr = 5'd12 + 5'(i); iAluData = 32'h400 + 32'(i);
      step();
    end
    idleInputs();
    iQAddr1 = 5'd12;
    #1;
    total++; if (oQHit1 !== 1'b1) $display("FAIL mid_hit_before got=%0b exp=1", oQHit1); else passed++;
    reset = 1'b0;
    #1;
    total++; if (oWe !== 1'b0) $display("FAIL mid_we got=%0b exp=0", oWe); else passed++;
    total++; if (oAluReady !== 1'b1) $display("FAIL mid_ready got=%0b exp=1", oAluReady); else passed++;
    total++; if (oQHit1 !== 1'b0) $display("FAIL mid_hit got=%0b exp=0", oQHit1); else passed++;
    @(negedge clk) reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if (oWe !== 1'b0) $display("FAIL mid_stale_%0d got we=%0b addr=%0d exp we=0", i, oWe, oWAddr); else passed++;
    end
  endtask

  initial begin
    iQAddr1 = '0; iQAddr2 = '0;
    test_reset();
    test_alu_only();
    test_back_to_back();
    test_collision();
    test_full();
    test_reg0();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
